music_seq_ctrl: RTL and testbench

- Playback sequencer for the per-track note ROMs. Each ROM maps an 8-bit quarter-beat index to a 32-bit tone frequency; 20000 means silence.
- Generates the beat index and track select, and takes play/pause/stop/next/prev commands from the debounced button layer.
- Gates the selected track's left/right tones to the audio divider stage. Silence is forced whenever the block is not playing.

---
 rtl/music_pkg.sv | 34 +++
 rtl/beat_tick_gen.sv | 47 ++++
 rtl/music_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_music_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
//   Shared types and constants for the music playback sequencer.
//   - state_t      : sequencer state (IDLE, PLAY, PAUSE)
//   - BEAT_W       : width of the quarter-beat index driven to the note ROMs
//   - TONE_W       : width of a tone frequency word
//   - SILENCE_TONE : tone value that means "no sound"
//   - wrap_inc/dec : modulo-N index stepping used for track selection
// -----------------------------------------------------------------------------
package music_pkg;

  localparam int BEAT_W = 8;
  localparam int TONE_W = 32;

  localparam logic [TONE_W-1:0] SILENCE_TONE = 32'd20000;
  localparam logic [BEAT_W-1:0] LAST_BEAT    = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Step an index up by one, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Step an index down by one, wrapping from 0 to n-1.
  function automatic int wrap_dec(input int idx, input int n);
    return (idx <= 0) ? n - 1 : idx - 1;
  endfunction

endpackage : music_pkg

// File: rtl/beat_tick_gen.sv
// -----------------------------------------------------------------------------
// beat_tick_gen
//   Clock-tick counter that divides the system clock into quarter-beat steps.
//   Counts 0..TICKS-1 while enabled and flags the terminal count.
//
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous reset, active-high (count -> 0)
//     en    in   advance the count this cycle
//     clr   in   force the count back to 0 (wins over en)
//     term  out  combinational: en is high and the count is at TICKS-1;
//                the count returns to 0 on this edge
// -----------------------------------------------------------------------------
module beat_tick_gen #(
  parameter int TICKS = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic term
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  // Gated by en so that a held count (paused, or a tick discarded in favour
  // of a command) never reports a terminal step.
  assign term = en && (cnt == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (term) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : beat_tick_gen

// File: rtl/music_seq_ctrl.sv
// -----------------------------------------------------------------------------
// music_seq_ctrl
//   Playback sequencer for the per-track note ROMs. Generates the quarter-beat
//   index and track select, executes play/pause/stop/next/prev commands, and
//   gates the selected track's tones to the audio divider stage (silence
//   whenever the sequencer is not playing).
//
//   Build option:
//     MUSIC_SEQ_AUTO_NEXT_EN  defined   : at end of track advance to the next
//                                         track and keep playing
//                             undefined : at end of track return to IDLE
//
//   Ports:
//     clk         in   system clock
//     rst         in   synchronous reset, active-high
//     cmd_play    in   pulse: start from IDLE or resume from PAUSE
//     cmd_pause   in   pulse: pause while playing
//     cmd_stop    in   pulse: stop and rewind (track kept)
//     cmd_next    in   pulse: next track, wrapping
//     cmd_prev    in   pulse: previous track, wrapping
//     tone_l_in   in   left tone from the selected track ROM
//     tone_r_in   in   right tone from the selected track ROM
//     ibeat_num   out  quarter-beat index driven to the ROMs
//     track       out  selected track
//     tone_l      out  gated left tone, registered
//     tone_r      out  gated right tone, registered
//     playing     out  high while in PLAY
//     track_done  out  one-cycle pulse when index 255 completes
//
//   Command priority in a cycle: stop > next/prev > play/pause. next and prev
//   together cancel each other out. Any command that takes effect discards a
//   coincident terminal tick.
// -----------------------------------------------------------------------------
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int                 CLK_HZ         = 100_000_000,
  parameter int                 TICKS_PER_BEAT = 25_000_000,
  parameter int                 NUM_TRACKS     = 4,
  parameter logic [TONE_W-1:0]  SILENCE        = SILENCE_TONE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_play,
  input  logic                          cmd_pause,
  input  logic                          cmd_stop,
  input  logic                          cmd_next,
  input  logic                          cmd_prev,
  input  logic [TONE_W-1:0]             tone_l_in,
  input  logic [TONE_W-1:0]             tone_r_in,
  output logic [BEAT_W-1:0]             ibeat_num,
  output logic [$clog2(NUM_TRACKS)-1:0] track,
  output logic [TONE_W-1:0]             tone_l,
  output logic [TONE_W-1:0]             tone_r,
  output logic                          playing,
  output logic                          track_done
);

  localparam int TRACK_W = $clog2(NUM_TRACKS);

  // Reject configurations the counter and track logic cannot represent.
  if (CLK_HZ <= 0 || TICKS_PER_BEAT < 2 || NUM_TRACKS < 2) begin : g_param_check
    $error("music_seq_ctrl: need CLK_HZ > 0, TICKS_PER_BEAT >= 2, NUM_TRACKS >= 2");
  end

  state_t               state;
  state_t               state_next;
  logic [BEAT_W-1:0]    ibeat_next;
  logic [TRACK_W-1:0]   track_next;
  logic                 done_next;

  logic                 go_next;
  logic                 go_prev;
  logic                 tick_en;
  logic                 tick_clr;
  logic                 tick_term;

  // Effective navigation: stop overrides it, and next+prev together is a no-op.
  assign go_next = cmd_next & ~cmd_prev & ~cmd_stop;
  assign go_prev = cmd_prev & ~cmd_next & ~cmd_stop;

  // The counter only runs in PLAY when no command takes effect this cycle.
  // cmd_play is ignored in PLAY, so it does not hold the counter.
  assign tick_en  = (state == PLAY) & ~cmd_stop & ~go_next & ~go_prev & ~cmd_pause;
  assign tick_clr = cmd_stop | go_next | go_prev;

  beat_tick_gen #(
    .TICKS (TICKS_PER_BEAT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .term (tick_term)
  );

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ibeat_next = ibeat_num;
    track_next = track;
    done_next  = 1'b0;

    if (cmd_stop) begin
      state_next = IDLE;
      ibeat_next = '0;
    end else if (go_next) begin
      track_next = TRACK_W'(wrap_inc(int'(track), NUM_TRACKS));
      ibeat_next = '0;
    end else if (go_prev) begin
      track_next = TRACK_W'(wrap_dec(int'(track), NUM_TRACKS));
      ibeat_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_play) state_next = PLAY;
        end
        PAUSE: begin
          // Counters were frozen, so playback resumes mid-step.
          if (cmd_play) state_next = PLAY;
        end
        PLAY: begin
          if (cmd_pause) begin
            state_next = PAUSE;
          end else if (tick_term) begin
            if (ibeat_num == LAST_BEAT) begin
              done_next  = 1'b1;
              ibeat_next = '0;
`ifdef MUSIC_SEQ_AUTO_NEXT_EN
              track_next = TRACK_W'(wrap_inc(int'(track), NUM_TRACKS));
`else
              state_next = IDLE;
`endif
            end else begin
              ibeat_next = ibeat_num + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous; it is just the highest-priority branch of the
  // clocked block, so it only takes effect on a rising clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ibeat_num  <= '0;
      track      <= '0;
      tone_l     <= SILENCE;
      tone_r     <= SILENCE;
      playing    <= 1'b0;
      track_done <= 1'b0;
    end else begin
      state      <= state_next;
      ibeat_num  <= ibeat_next;
      track      <= track_next;
      track_done <= done_next;
      playing    <= (state_next == PLAY);
      // Tones are gated on the state being entered, so they fall silent in
      // the same cycle the sequencer leaves PLAY.
      tone_l     <= (state_next == PLAY) ? tone_l_in : SILENCE;
      tone_r     <= (state_next == PLAY) ? tone_r_in : SILENCE;
    end
  end

endmodule : music_seq_ctrl

// File: tb/tb_music_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_music_seq_ctrl
//   Self-checking bench for music_seq_ctrl with TICKS_PER_BEAT=4 and
//   NUM_TRACKS=4. A reference model tracks the playback position in clock
//   ticks within the track and derives the beat index from it; a compare
//   process checks every output on every falling edge. Directed scenarios add
//   hand-computed literal expectations, followed by randomized command traffic.
// -----------------------------------------------------------------------------
module tb_music_seq_ctrl;

  localparam int          TPB = 4;
  localparam int          NT  = 4;
  localparam logic [31:0] SIL = 32'd20000;
  localparam int          TRACK_TICKS = 256 * TPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_play, cmd_pause, cmd_stop, cmd_next, cmd_prev;
  logic [31:0] tone_l_in, tone_r_in;
  logic [7:0]  ibeat_num;
  logic [1:0]  track;
  logic [31:0] tone_l, tone_r;
  logic        playing, track_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  music_seq_ctrl #(
    .CLK_HZ         (100),
    .TICKS_PER_BEAT (TPB),
    .NUM_TRACKS     (NT),
    .SILENCE        (SIL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_play   (cmd_play),
    .cmd_pause  (cmd_pause),
    .cmd_stop   (cmd_stop),
    .cmd_next   (cmd_next),
    .cmd_prev   (cmd_prev),
    .tone_l_in  (tone_l_in),
    .tone_r_in  (tone_r_in),
    .ibeat_num  (ibeat_num),
    .track      (track),
    .tone_l     (tone_l),
    .tone_r     (tone_r),
    .playing    (playing),
    .track_done (track_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position counted in ticks from the start of the track.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_PLAY, M_PAUSE} mmode_t;

  mmode_t      m_mode  = M_IDLE;
  int          m_pos   = 0;
  int          m_track = 0;
  logic [31:0] m_tl    = SIL;
  logic [31:0] m_tr    = SIL;
  bit          m_done  = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    bit do_next, do_prev;
    m_done = 1'b0;
    if (rst) begin
      m_mode  = M_IDLE;
      m_pos   = 0;
      m_track = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      do_next = cmd_next && !cmd_prev;
      do_prev = cmd_prev && !cmd_next;
      if (cmd_stop) begin
        m_mode = M_IDLE;
        m_pos  = 0;
      end else if (do_next) begin
        m_track = (m_track + 1) % NT;
        m_pos   = 0;
      end else if (do_prev) begin
        m_track = (m_track + NT - 1) % NT;
        m_pos   = 0;
      end else if (cmd_play && m_mode != M_PLAY) begin
        m_mode = M_PLAY;
      end else if (cmd_pause && m_mode == M_PLAY) begin
        m_mode = M_PAUSE;
      end else if (m_mode == M_PLAY) begin
        m_pos++;
        if (m_pos == TRACK_TICKS) begin
          m_done = 1'b1;
          m_pos  = 0;
`ifdef MUSIC_SEQ_AUTO_NEXT_EN
          m_track = (m_track + 1) % NT;
`else
          m_mode = M_IDLE;
`endif
        end
      end
    end
    m_tl = (m_mode == M_PLAY) ? tone_l_in : SIL;
    m_tr = (m_mode == M_PLAY) ? tone_r_in : SIL;
  end

  // Compare process: every output, every cycle, once the model is in step.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ibeat_num",  ibeat_num,  32'(m_pos / TPB));
      check("track",      track,      32'(m_track));
      check("tone_l",     tone_l,     m_tl);
      check("tone_r",     tone_r,     m_tr);
      check("playing",    playing,    32'(m_mode == M_PLAY));
      check("track_done", track_done, 32'(m_done));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge only.
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle command combination; returns one falling edge after the
  // rising edge that sampled it.
  task automatic pulse(input bit play, input bit pause, input bit stop,
                       input bit nxt, input bit prv);
    cmd_play  = play;
    cmd_pause = pause;
    cmd_stop  = stop;
    cmd_next  = nxt;
    cmd_prev  = prv;
    @(negedge clk);
    cmd_play  = 1'b0;
    cmd_pause = 1'b0;
    cmd_stop  = 1'b0;
    cmd_next  = 1'b0;
    cmd_prev  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ibeat"},   ibeat_num,  32'd0);
    check({tag, " track"},   track,      32'd0);
    check({tag, " tone_l"},  tone_l,     SIL);
    check({tag, " tone_r"},  tone_r,     SIL);
    check({tag, " playing"}, playing,    32'd0);
    check({tag, " done"},    track_done, 32'd0);
  endtask

  initial begin
    logic [1:0] trk_before;

    rst       = 1'b1;
    cmd_play  = 1'b0;
    cmd_pause = 1'b0;
    cmd_stop  = 1'b0;
    cmd_next  = 1'b0;
    cmd_prev  = 1'b0;
    tone_l_in = 32'd588;
    tone_r_in = 32'd700;

    // Reset values.
    wait_cycles(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cycles(2);

    // Play from IDLE: index steps after exactly 4 cycles, tones pass through.
    pulse(1, 0, 0, 0, 0);
    check("play entry ibeat",   ibeat_num, 32'd0);
    check("play entry tone_l",  tone_l,    32'd588);
    check("play entry tone_r",  tone_r,    32'd700);
    check("play entry playing", playing,   32'd1);
    wait_cycles(3);
    check("ibeat before step", ibeat_num, 32'd0);
    wait_cycles(1);
    check("ibeat first step",  ibeat_num, 32'd1);

    // Advance to index 10, pause two ticks into the step, then resume.
    wait_cycles(9 * TPB);
    check("ibeat at 10", ibeat_num, 32'd10);
    wait_cycles(2);
    pulse(0, 1, 0, 0, 0);
    wait_cycles(20);
    check("paused ibeat",   ibeat_num, 32'd10);
    check("paused tone_l",  tone_l,    SIL);
    check("paused playing", playing,   32'd0);
    pulse(1, 0, 0, 0, 0);
    check("resume ibeat",   ibeat_num, 32'd10);
    wait_cycles(1);
    check("resume ibeat +1", ibeat_num, 32'd10);
    wait_cycles(1);
    check("resume ibeat step", ibeat_num, 32'd11);

    // Track navigation with wrap in both directions.
    pulse(0, 0, 0, 0, 1);
    check("prev wrap track", track,     32'd3);
    check("prev wrap ibeat", ibeat_num, 32'd0);
    pulse(0, 0, 0, 1, 0);
    check("next wrap track", track,     32'd0);
    check("next wrap ibeat", ibeat_num, 32'd0);
    wait_cycles(2 * TPB);
    pulse(0, 0, 0, 1, 1);
    check("next+prev track", track,     32'd0);
    check("next+prev ibeat", ibeat_num, 32'd2);

    // Full track from a fresh start.
    pulse(0, 0, 1, 0, 0);
    check("stop playing", playing, 32'd0);
    pulse(1, 0, 0, 0, 0);
    wait_cycles(TRACK_TICKS - 1);
    check("eot ibeat 255",  ibeat_num,  32'd255);
    check("eot done low",   track_done, 32'd0);
    wait_cycles(1);
    check("eot done pulse", track_done, 32'd1);
    check("eot ibeat 0",    ibeat_num,  32'd0);
`ifdef MUSIC_SEQ_AUTO_NEXT_EN
    check("eot track advanced", track,   32'd1);
    check("eot still playing",  playing, 32'd1);
    check("eot tone_l",         tone_l,  32'd588);
`else
    check("eot track kept", track,   32'd0);
    check("eot idle",       playing, 32'd0);
    check("eot tone_l",     tone_l,  SIL);
`endif
    wait_cycles(1);
    check("eot done single", track_done, 32'd0);

    // Stop wins over next and play at index 100.
    pulse(0, 0, 1, 0, 0);
    pulse(1, 0, 0, 0, 0);
    wait_cycles(100 * TPB);
    check("idx 100", ibeat_num, 32'd100);
    trk_before = track;
    pulse(1, 0, 1, 1, 0);
    check("stop prio ibeat",   ibeat_num, 32'd0);
    check("stop prio playing", playing,   32'd0);
    check("stop prio track",   track,     32'(trk_before));

    // Reset mid-play at index 77, held for three cycles.
    pulse(0, 0, 0, 1, 0);
    pulse(1, 0, 0, 0, 0);
    wait_cycles(77 * TPB);
    check("idx 77", ibeat_num, 32'd77);
    rst = 1'b1;
    wait_cycles(1);
    check_reset_outputs("midplay reset c1");
    wait_cycles(2);
    check_reset_outputs("midplay reset c3");
    rst = 1'b0;

    // Randomized traffic: dense commands, then sparse to let tracks finish.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      cmd_play  = ($urandom_range(0, 99) < 6);
      cmd_pause = ($urandom_range(0, 99) < 4);
      cmd_stop  = ($urandom_range(0, 99) < 2);
      cmd_next  = ($urandom_range(0, 99) < 3);
      cmd_prev  = ($urandom_range(0, 99) < 3);
      tone_l_in = $urandom;
      tone_r_in = $urandom;
      @(negedge clk);
    end
    for (int i = 0; i < 6000; i++) begin
      rst       = 1'b0;
      cmd_play  = ($urandom_range(0, 199) == 0);
      cmd_pause = ($urandom_range(0, 2999) == 0);
      cmd_stop  = ($urandom_range(0, 2999) == 0);
      cmd_next  = ($urandom_range(0, 2999) == 0);
      cmd_prev  = ($urandom_range(0, 2999) == 0);
      tone_l_in = $urandom;
      tone_r_in = $urandom;
      @(negedge clk);
    end

    rst       = 1'b0;
    cmd_play  = 1'b0;
    cmd_pause = 1'b0;
    cmd_stop  = 1'b0;
    cmd_next  = 1'b0;
    cmd_prev  = 1'b0;
    wait_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_music_seq_ctrl
